chdr_pkt_arbiter: RTL

CHDR_PKT_ARBITER -- requirements
Module: chdr_pkt_arbiter

---
 rtl/chdr_pkt_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/chdr_pkt_arbiter.sv
// Packet-atomic round-robin arbiter for 64-bit CHDR streams. The datapath is
// combinational; an optional per-port counter rewrites the header seqnum.
module chdr_pkt_arbiter #(
   parameter int NUM_PORTS   = 2,
   parameter int REWRITE_SEQ = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [64*NUM_PORTS-1:0]   i_tdata,
   input  logic [NUM_PORTS-1:0]      i_tlast,
   input  logic [NUM_PORTS-1:0]      i_tvalid,
   output logic [NUM_PORTS-1:0]      i_tready,
   output logic [63:0]               o_tdata,
   output logic                      o_tlast,
   output logic                      o_tvalid,
   input  logic                      o_tready,
   output logic [1:0]                o_port
);

   // Handshake: a word moves when valid and ready are both high in the same
   // cycle; valid never waits on ready, and data/last are stable while held.
   typedef enum logic {ST_IDLE, ST_PKT} state_t;

   state_t      state, state_nxt;
   logic [1:0]  last_grant, grant_nxt, cand;
   logic        found;
   logic        first_beat;
   logic [11:0] seq_cnt [4];
   logic [3:0]  req_vec, last_vec;
   logic [63:0] word_arr [4];
   logic        sel_valid, sel_last;
   logic [63:0] sel_word;
   logic        xfer;

   // Pad per-port inputs to four entries so a 2-bit grant can index them directly.
   always_comb begin
      req_vec  = '0;
      last_vec = '0;
      for (int p = 0; p < 4; p++) word_arr[p] = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         req_vec[p]  = i_tvalid[p];
         last_vec[p] = i_tlast[p];
         word_arr[p] = i_tdata[64*p +: 64];
      end
   end

   always_comb begin
      grant_nxt = last_grant;
      found     = 1'b0;
      cand      = '0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         cand = 2'((int'(last_grant) + i) % NUM_PORTS);
         if (!found && req_vec[cand]) begin
            found     = 1'b1;
            grant_nxt = cand;
         end
      end
   end

   // last_grant is loaded on entry to ST_PKT, so it is the active grant there.
   assign sel_valid = req_vec[last_grant];
   assign sel_last  = last_vec[last_grant];
   assign sel_word  = word_arr[last_grant];
   assign xfer      = (state == ST_PKT) && sel_valid && o_tready;

   always_comb begin
      state_nxt = state;
      o_tvalid  = 1'b0;
      o_tlast   = 1'b0;
      o_port    = 2'd0;
      i_tready  = '0;
      case (state)
         ST_IDLE: begin
            if (|req_vec) state_nxt = ST_PKT;
         end
         ST_PKT: begin
            o_tvalid = sel_valid;
            o_tlast  = sel_last;
            o_port   = last_grant;
            for (int p = 0; p < NUM_PORTS; p++)
               if (2'(p) == last_grant) i_tready[p] = o_tready;
            if (xfer && sel_last) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      o_tdata = sel_word;
      if (REWRITE_SEQ != 0 && first_beat) o_tdata[59:48] = seq_cnt[last_grant];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         last_grant <= 2'(NUM_PORTS - 1);
         first_beat <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && |req_vec) begin
            last_grant <= grant_nxt;
            first_beat <= 1'b1;
         end else if (xfer) begin
            first_beat <= 1'b0;
         end
      end
   end

   // Counter advances after the packet completes, so the header used the old value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int p = 0; p < 4; p++) seq_cnt[p] <= '0;
      end else if (REWRITE_SEQ != 0 && xfer && sel_last) begin
         seq_cnt[last_grant] <= seq_cnt[last_grant] + 12'd1;
      end
   end

endmodule
